// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/halt control with saturating stall and flush counters
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       Rs_dec,
  input  logic [4:0]       Rt_dec,
  input  logic             useRt_dec,
  input  logic [4:0]       Rd_ex,
  input  logic             memRead_ex,
  input  logic             redirect_ex,
  input  logic             ihit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             dhit,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifde_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifde_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic dwait, loaduse, run, redir;
  assign dwait   = (dREN_mem | dWEN_mem) & ~dhit;
  assign loaduse = memRead_ex & (Rd_ex != 5'd0) &
                   ((Rd_ex == Rs_dec) | (useRt_dec & (Rd_ex == Rt_dec)));
  assign run     = nRST & (state == RUN);
  // a redirect under dwait is held in execute and serviced once the wait clears
  assign redir   = run & ~dwait & redirect_ex;
  always_comb begin
    pc_en       = run;
    pc_redirect = 1'b0;
    ifde_en     = run;
    idex_en     = run;
    exmem_en    = run;
    memwb_en    = run;
    ifde_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (run) begin
      if (dwait) begin
        pc_en       = 1'b0;
        ifde_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else if (redirect_ex) begin
        pc_redirect = 1'b1;
        ifde_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (loaduse) begin
        pc_en      = 1'b0;
        ifde_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (~ihit) begin
        pc_en      = 1'b0;
        ifde_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == RUN) begin
      if (halt_mem && !dwait) begin
        state <= HALT;
        halt  <= 1'b1;
      end
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redir && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors against hand-computed control words and counter values
module tb_hazard_unit;
  localparam int W = 4;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [4:0] Rs_dec, Rt_dec, Rd_ex;
  logic useRt_dec, memRead_ex, redirect_ex, ihit, dREN_mem, dWEN_mem, dhit, halt_mem;
  logic pc_en, pc_redirect, ifde_en, idex_en, exmem_en, memwb_en;
  logic ifde_flush, idex_flush, memwb_flush, halt;
  logic [W-1:0] stall_cnt, flush_cnt;
  int n_cmp = 0, n_bad = 0;
  // control word: pc_en pc_redirect ifde idex exmem memwb | ifde_f idex_f memwb_f
  localparam logic [8:0] NORM = 9'b101111000, LU = 9'b000111010, DW = 9'b000001001,
                         RD = 9'b111111110, IM = 9'b001111100, OFF = 9'b000000000;
  logic [8:0] ctrl;
  assign ctrl = {pc_en, pc_redirect, ifde_en, idex_en, exmem_en, memwb_en,
                 ifde_flush, idex_flush, memwb_flush};

  hazard_unit #(.CNT_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .Rs_dec(Rs_dec), .Rt_dec(Rt_dec), .useRt_dec(useRt_dec),
    .Rd_ex(Rd_ex), .memRead_ex(memRead_ex), .redirect_ex(redirect_ex), .ihit(ihit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dhit(dhit), .halt_mem(halt_mem),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifde_en(ifde_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifde_flush(ifde_flush),
    .idex_flush(idex_flush), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Rs_dec = 5'd1; Rt_dec = 5'd2; useRt_dec = 1'b0; Rd_ex = 5'd3; memRead_ex = 1'b0;
    redirect_ex = 1'b0; ihit = 1'b1; dREN_mem = 1'b0; dWEN_mem = 1'b0; dhit = 1'b0;
    halt_mem = 1'b0;
  endtask

  task automatic cnts(input string tag, input int s, input int f, input logic h);
    check({tag, "_stall"}, 32'(stall_cnt), s);
    check({tag, "_flush"}, 32'(flush_cnt), f);
    check({tag, "_halt"}, 32'(halt), 32'(h));
  endtask

  initial begin
    idle();
    step(); step();
    check("reset_ctrl", 32'(ctrl), 32'(OFF));
    cnts("reset", 0, 0, 1'b0);
    nRST = 1'b1;
    #1 check("idle", 32'(ctrl), 32'(NORM));
    step();
    cnts("idle", 0, 0, 1'b0);
    memRead_ex = 1'b1; Rd_ex = 5'd5; Rs_dec = 5'd5;
    #1 check("lu_rs", 32'(ctrl), 32'(LU));
    step();
    cnts("lu_rs", 1, 0, 1'b0);
    Rd_ex = 5'd0; Rs_dec = 5'd0;
    #1 check("lu_r0", 32'(ctrl), 32'(NORM));
    Rd_ex = 5'd7; Rt_dec = 5'd7; Rs_dec = 5'd1;
    #1 check("lu_rt_unused", 32'(ctrl), 32'(NORM));
    useRt_dec = 1'b1;
    #1 check("lu_rt", 32'(ctrl), 32'(LU));
    step();
    cnts("lu_rt", 2, 0, 1'b0);
    idle();
    dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("dwait", 32'(ctrl), 32'(DW));
      step();
    end
    cnts("dwait", 5, 0, 1'b0);
    dhit = 1'b1;
    #1 check("dwait_done", 32'(ctrl), 32'(NORM));
    step();
    cnts("dwait_done", 5, 0, 1'b0);
    dhit = 1'b0; dWEN_mem = 1'b1; dREN_mem = 1'b0;
    redirect_ex = 1'b1; memRead_ex = 1'b1; Rd_ex = 5'd9; Rs_dec = 5'd9;
    for (int i = 0; i < 2; i++) begin
      #1 check("rd_dwait", 32'(ctrl), 32'(DW));
      step();
    end
    cnts("rd_dwait", 7, 0, 1'b0);
    dhit = 1'b1;
    #1 check("rd_lu", 32'(ctrl), 32'(RD));
    step();
    cnts("rd_lu", 7, 1, 1'b0);
    idle();
    ihit = 1'b0;
    #1 check("imiss", 32'(ctrl), 32'(IM));
    step();
    cnts("imiss", 8, 1, 1'b0);
    ihit = 1'b1; halt_mem = 1'b1; dREN_mem = 1'b1;
    #1 check("halt_dwait", 32'(ctrl), 32'(DW));
    step();
    cnts("halt_dwait", 9, 1, 1'b0);
    dhit = 1'b1;
    #1 check("halt_enter", 32'(ctrl), 32'(NORM));
    step();
    cnts("halt_enter", 9, 1, 1'b1);
    idle();
    redirect_ex = 1'b1; ihit = 1'b0;
    #1 check("halted", 32'(ctrl), 32'(OFF));
    step(); step();
    cnts("halted", 9, 1, 1'b1);
    #2 nRST = 1'b0;
    #1 cnts("async_rst", 0, 0, 1'b0);
    check("async_rst_ctrl", 32'(ctrl), 32'(OFF));
    step();
    nRST = 1'b1;
    idle();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step();
    cnts("sat", 15, 0, 1'b0);
    check("sat_ctrl", 32'(ctrl), 32'(IM));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
